uart_rx_fsm: RTL and testbench

- Frame-control state machine of the UART receiver.
- Consumes the bit/edge counts produced by the edge/bit counter and drives that counter's enable.
- Sequences sampler, deserializer and start/parity/stop checkers through one serial frame: start bit, 8 data bits, optional parity bit, stop bit.
- Reports frame completion as a one-cycle o_data_valid pulse, or a one-cycle o_frame_err pulse if the frame failed.

---
 rtl/uart_rx_pkg.sv | 25 ++
 rtl/uart_rx_fsm.sv | 136 +++++++++++++
 tb/tb_uart_rx_fsm.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver frame-control logic.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        ABORT
    } state_e;

    localparam int unsigned START_BIT     = 0;
    localparam int unsigned LAST_DATA_BIT = 8;
    localparam int unsigned PAR_BIT       = 9;

    localparam int unsigned PRESCALE_8  = 8;
    localparam int unsigned PRESCALE_16 = 16;
    localparam int unsigned PRESCALE_32 = 32;

    function automatic logic prescale_legal(input int unsigned p);
        return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
    endfunction

endpackage

// File: rtl/uart_rx_fsm.sv
// UART receiver frame sequencer: walks start/data/parity/stop bits using the
// external edge/bit counter and reports a registered good-frame or error pulse.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6,
    parameter int EDGE_W     = 5,
    parameter int BIT_W      = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_RX_IN,
    input  logic                  i_PAR_EN,
    input  logic [PRESCALE_W-1:0] i_Prescale,
    input  logic [BIT_W-1:0]      i_bit_cnt,
    input  logic [EDGE_W-1:0]     i_edge_cnt,
    input  logic                  i_strt_glitch,
    input  logic                  i_par_err,
    input  logic                  i_stp_err,
    output logic                  o_cnt_enable,
    output logic                  o_dat_samp_en,
    output logic                  o_deser_en,
    output logic                  o_strt_chk_en,
    output logic                  o_par_chk_en,
    output logic                  o_stp_chk_en,
    output logic                  o_data_valid,
    output logic                  o_frame_err
);

    state_e state_q, state_d;
    logic   par_err_q, par_err_d;
    logic   stp_err_q, stp_err_d;
    logic   data_valid_q, data_valid_d;
    logic   frame_err_q, frame_err_d;

    logic [PRESCALE_W-1:0] edge_ext;
    logic                  is_end;
    logic                  is_chk;
    logic [BIT_W-1:0]      last_bit;
    logic [BIT_W-1:0]      stop_bit;

    assign edge_ext = PRESCALE_W'(i_edge_cnt);
    assign is_end   = (edge_ext == i_Prescale - PRESCALE_W'(1));
    // One edge after the sampler's final mid-bit sample, so checker results are settled.
    assign is_chk   = (edge_ext == (i_Prescale >> 1) + PRESCALE_W'(2));
    assign last_bit = i_PAR_EN ? BIT_W'(PAR_BIT) : BIT_W'(LAST_DATA_BIT);
    assign stop_bit = last_bit + BIT_W'(1);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= IDLE;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        par_err_d     = par_err_q;
        stp_err_d     = stp_err_q;
        data_valid_d  = 1'b0;
        frame_err_d   = 1'b0;
        o_cnt_enable  = 1'b0;
        o_dat_samp_en = 1'b0;
        o_deser_en    = 1'b0;
        o_strt_chk_en = 1'b0;
        o_par_chk_en  = 1'b0;
        o_stp_chk_en  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!i_RX_IN) state_d = START;
            end
            START: begin
                o_cnt_enable  = 1'b1;
                o_dat_samp_en = 1'b1;
                o_strt_chk_en = is_chk;
                if (is_chk && i_strt_glitch) begin
                    state_d = ABORT;
                end else if (is_end && i_bit_cnt == BIT_W'(START_BIT)) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                o_cnt_enable  = 1'b1;
                o_dat_samp_en = 1'b1;
                o_deser_en    = is_chk;
                if (is_end && i_bit_cnt == BIT_W'(LAST_DATA_BIT)) begin
                    state_d = i_PAR_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                o_cnt_enable  = 1'b1;
                o_dat_samp_en = 1'b1;
                o_par_chk_en  = is_chk;
                if (is_chk) par_err_d = i_par_err;
                if (is_end && i_bit_cnt == BIT_W'(PAR_BIT)) state_d = STOP;
            end
            STOP: begin
                o_cnt_enable  = 1'b1;
                o_dat_samp_en = 1'b1;
                o_stp_chk_en  = is_chk;
                if (is_chk) stp_err_d = i_stp_err;
                if (is_end && i_bit_cnt == stop_bit) begin
                    state_d      = IDLE;
                    data_valid_d = !(par_err_q || stp_err_q);
                    frame_err_d  = par_err_q || stp_err_q;
                    par_err_d    = 1'b0;
                    stp_err_d    = 1'b0;
                end
            end
            ABORT: begin
                // Keep counting so the counter drains back to 0/0 at the frame boundary.
                o_cnt_enable = 1'b1;
                if (is_end && i_bit_cnt == stop_bit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if (state_q != IDLE) assert (prescale_legal(32'(i_Prescale)));
    end

    assign o_data_valid = data_valid_q;
    assign o_frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: drives whole frames against a counter model and checks
// every strobe against a per-frame timetable derived from bit/edge arithmetic.
module tb_uart_rx_fsm;
    import uart_rx_pkg::*;

    localparam int PW = 6;
    localparam int EW = 5;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx = 1'b1;
    logic          par_en = 1'b0;
    logic [PW-1:0] prescale = PW'(8);
    logic [BW-1:0] bit_cnt;
    logic [EW-1:0] edge_cnt;
    logic          strt_glitch = 1'b0;
    logic          par_err = 1'b0;
    logic          stp_err = 1'b0;
    logic          cnt_en, samp_en, deser_en, strt_chk, par_chk, stp_chk, dv, fe;
    logic [7:0]    outs;

    int n_checks = 0;
    int n_pass   = 0;

    uart_rx_fsm #(.PRESCALE_W(PW), .EDGE_W(EW), .BIT_W(BW)) dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_RX_IN       (rx),
        .i_PAR_EN      (par_en),
        .i_Prescale    (prescale),
        .i_bit_cnt     (bit_cnt),
        .i_edge_cnt    (edge_cnt),
        .i_strt_glitch (strt_glitch),
        .i_par_err     (par_err),
        .i_stp_err     (stp_err),
        .o_cnt_enable  (cnt_en),
        .o_dat_samp_en (samp_en),
        .o_deser_en    (deser_en),
        .o_strt_chk_en (strt_chk),
        .o_par_chk_en  (par_chk),
        .o_stp_chk_en  (stp_chk),
        .o_data_valid  (dv),
        .o_frame_err   (fe)
    );

    assign outs = {cnt_en, samp_en, deser_en, strt_chk, par_chk, stp_chk, dv, fe};

    always #5 clk = ~clk;

    // Edge/bit counter the FSM controls; wraps to 0/0 after the stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            edge_cnt <= '0;
        end else if (cnt_en) begin
            if ({1'b0, edge_cnt} == prescale - PW'(1)) begin
                edge_cnt <= '0;
                bit_cnt  <= (bit_cnt == (par_en ? BW'(10) : BW'(9))) ? '0 : bit_cnt + BW'(1);
            end else begin
                edge_cnt <= edge_cnt + EW'(1);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    function automatic logic line_bit(input int f, input int p, input logic [7:0] d, input bit pe);
        int b;
        b = f / p;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (b == 9 && pe) return ^d;
        return 1'b1;
    endfunction

    // Expected strobes for cycle f of a frame (f=0 is the first cycle after RX falls).
    function automatic logic [7:0] exp_outs(input int f, input int p, input bit pe,
                                            input bit g, input bit pr, input bit sr);
        int  c, last, total;
        bit  en, samp, des, st, pc, sc, bad;
        c     = p / 2 + 2;
        last  = pe ? 9 : 8;
        total = (last + 2) * p;
        en    = (f < total);
        samp  = en && !(g && f > c);
        des   = 1'b0;
        for (int k = 1; k <= 8; k++) if (!g && f == k * p + c) des = 1'b1;
        st    = (f == c);
        pc    = !g && pe && (f == 9 * p + c);
        sc    = !g && (f == (last + 1) * p + c);
        bad   = (pe && pr) || sr;
        return {en, samp, des, st, pc, sc, (f == total) && !g && !bad, (f == total) && !g && bad};
    endfunction

    task automatic idle_cycles(input int n);
        rx = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
            check_eq("idle_outs", 32'(outs), 32'h0);
        end
    endtask

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the first IDLE cycle after the frame.
    task automatic run_frame(input logic [7:0] d, input int p, input bit pe,
                             input bit g, input bit pr, input bit sr);
        int         total;
        logic [7:0] cap;
        prescale    = PW'(p);
        par_en      = pe;
        strt_glitch = g;
        par_err     = pr;
        stp_err     = sr;
        rx          = 1'b0;
        total       = ((pe ? 9 : 8) + 2) * p;
        cap         = '0;
        for (int f = 0; f <= total; f++) begin
            @(posedge clk); #1;
            check_eq($sformatf("outs p=%0d pe=%0d g=%0d f=%0d", p, pe, g, f),
                     32'(outs), 32'(exp_outs(f, p, pe, g, pr, sr)));
            if (deser_en) cap = {line_bit(f, p, d, pe), cap[7:1]};
            rx = line_bit(f, p, d, pe);
        end
        check_eq("cnt_wrap", 32'({bit_cnt, edge_cnt}), 32'h0);
        if (!g) check_eq("deser_byte", 32'(cap), 32'(d));
    endtask

    initial begin
        int p_tab [3];
        p_tab[0] = PRESCALE_8;
        p_tab[1] = PRESCALE_16;
        p_tab[2] = PRESCALE_32;

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outs", 32'(outs), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(3);

        run_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_cycles(2);
        run_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b0);
        idle_cycles(2);
        run_frame(8'hFF, 8, 1'b0, 1'b1, 1'b0, 1'b0);
        idle_cycles(2);
        run_frame(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_cycles(2);
        run_frame(8'h5A, 32, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_cycles(2);

        // Reset in the middle of data bit 4.
        prescale    = PW'(8);
        par_en      = 1'b0;
        strt_glitch = 1'b0;
        par_err     = 1'b0;
        stp_err     = 1'b0;
        rx          = 1'b0;
        for (int f = 0; f <= 4 * 8 + 3; f++) begin
            @(posedge clk); #1;
            rx = line_bit(f, 8, 8'h96, 1'b0);
        end
        check_eq("pre_reset_cnt_en", 32'(cnt_en), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_reset_outs", 32'(outs), 32'h0);
        check_eq("async_reset_cnt", 32'({bit_cnt, edge_cnt}), 32'h0);
        @(negedge clk);
        rx    = 1'b1;
        rst_n = 1'b1;
        idle_cycles(20);

        repeat (20) begin
            logic [7:0] d;
            int         p;
            bit         pe, g, pr, sr;
            d  = 8'($urandom);
            p  = p_tab[$urandom_range(0, 2)];
            pe = 1'($urandom_range(0, 1));
            g  = ($urandom_range(0, 5) == 0);
            pr = ($urandom_range(0, 3) == 0);
            sr = ($urandom_range(0, 3) == 0);
            run_frame(d, p, pe, g, pr, sr);
            if ($urandom_range(0, 1) == 0) idle_cycles($urandom_range(1, 5));
        end
        idle_cycles(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
